// File: rtl/gpr_dump_if.sv
// gpr_dump_if: GPR read-port, control and valid/ready stream signals of gpr_dump.
// GPR_DUMP_CSUM_EN adds the csum signal.
interface gpr_dump_if;
  logic        start;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        gpr_sel;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
`ifdef GPR_DUMP_CSUM_EN
  logic [31:0] csum;
`endif
  modport master (
    input  start, rd_data, out_ready,
    output rd_addr, gpr_sel, busy, done, out_valid, out_idx, out_data
`ifdef GPR_DUMP_CSUM_EN
    , csum
`endif
  );
  modport slave (
    output start, rd_data, out_ready,
    input  rd_addr, gpr_sel, busy, done, out_valid, out_idx, out_data
`ifdef GPR_DUMP_CSUM_EN
    , csum
`endif
  );
endinterface

// File: rtl/gpr_dump.sv
// gpr_dump: walks GPRs FIRST_REG..LAST_REG and streams {index, data} words.
// GPR_DUMP_CSUM_EN adds a running XOR checksum of accepted words.
module gpr_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input logic        clk,
  input logic        rst,
  gpr_dump_if.master bus
);
  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);
  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;
  state_t      state, state_nxt;
  logic [4:0]  idx, out_idx;
  logic [31:0] out_data;
  logic        go, acc;
  assign go  = state == IDLE && bus.start;
  assign acc = state == SEND && bus.out_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (bus.start ? READ : IDLE) :
                state == READ ? SEND :
                state == SEND ? (bus.out_ready ? (idx == LAST ? FIN : READ) : SEND) :
                IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx      <= '0;
      out_idx  <= '0;
      out_data <= '0;
    end else begin
      if (go) idx <= FIRST;
      else if (acc && idx != LAST) idx <= idx + 5'd1;
      if (state == READ) begin
        out_idx  <= idx;
        out_data <= bus.rd_data;
      end
    end
`ifdef GPR_DUMP_CSUM_EN
  logic [31:0] csum;
  always_ff @(posedge clk or negedge rst)
    if (!rst)     csum <= '0;
    else if (go)  csum <= '0;
    else if (acc) csum <= csum ^ out_data;
  assign bus.csum = csum;
`endif
  assign bus.rd_addr   = idx;
  assign bus.gpr_sel   = state == READ || state == SEND;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == FIN;
  assign bus.out_valid = state == SEND;
  assign bus.out_idx   = out_idx;
  assign bus.out_data  = out_data;
endmodule
